data_stack: RTL and testbench



---
 rtl/stack_pkg.sv | 14 +
 rtl/stack_regfile.sv | 21 ++
 rtl/data_stack.sv | 77 +++++++
 tb/tb_data_stack.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: shared sizes and the control FSM's stack opcode encoding.
package stack_pkg;
   localparam int STACK_WIDTH = 16;
   localparam int STACK_DEPTH = 32;
   localparam int STACK_CNT_W = $clog2(STACK_DEPTH) + 1;
   typedef enum logic [3:0] {
      OP_NOP, OP_PUSH, OP_PUSH_I, OP_PUSH_T, OP_POP,
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
      OP_JMP, OP_JZ, OP_CALL, OP_RET
   } stack_op_e;
   function automatic logic op_pushes(stack_op_e op);
      return op inside {OP_PUSH, OP_PUSH_I, OP_PUSH_T, OP_CALL};
   endfunction
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: DEPTH x WIDTH storage, one synchronous write port, two asynchronous read ports.
module stack_regfile #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    rd0_addr_i,
   input  logic [AW-1:0]    rd1_addr_i,
   output logic [WIDTH-1:0] rd0_data_o,
   output logic [WIDTH-1:0] rd1_data_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;
   assign rd0_data_o = mem_q[rd0_addr_i];
   assign rd1_data_o = mem_q[rd1_addr_i];
endmodule

// File: rtl/data_stack.sv
// data_stack: operand LIFO with a registered pop output, top/next views and sticky error flags.
module data_stack
   import stack_pkg::*;
#(
   parameter int WIDTH = STACK_WIDTH,
   parameter int DEPTH = STACK_DEPTH,
   parameter int CNT_W = STACK_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic [WIDTH-1:0] tos,
   output logic [WIDTH-1:0] nos,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);
   localparam int AW = $clog2(DEPTH);
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             pop_ok, push_ok, we;
   logic [AW-1:0]    top_addr, waddr;
   logic [WIDTH-1:0] rd0, rd1;
   assign empty    = count_q == '0;
   assign full     = count_q == CNT_W'(DEPTH);
   assign pop_ok   = pop && !empty;
   // A simultaneous pop frees the top slot, so a push into a full stack still lands.
   assign push_ok  = push && (!full || pop_ok);
   // Low address bits alone suffice: count==DEPTH wraps to index DEPTH-1 as intended.
   assign top_addr = count_q[AW-1:0] - AW'(1);
   assign waddr    = pop_ok ? top_addr : count_q[AW-1:0];
   assign we       = push_ok && !clear && !rst;
   always_comb begin
      count_d    = clear ? '0 :
                   (push_ok && !pop_ok) ? count_q + CNT_W'(1) :
                   (pop_ok && !push_ok) ? count_q - CNT_W'(1) : count_q;
      data_out_d = clear ? '0 : pop_ok ? rd0 : data_out_q;
      ovf_d      = !clear && (ovf_q || (push && full && !pop_ok));
      unf_d      = !clear && (unf_q || (pop && empty));
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         data_out_q <= '0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         count_q    <= count_d;
         data_out_q <= data_out_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end
   stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_regfile (
      .clk        (clk),
      .we_i       (we),
      .waddr_i    (waddr),
      .wdata_i    (data_in),
      .rd0_addr_i (top_addr),
      .rd1_addr_i (top_addr - AW'(1)),
      .rd0_data_o (rd0),
      .rd1_data_o (rd1)
   );
   assign data_out  = data_out_q;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign tos       = empty ? '0 : rd0;
   assign nos       = (count_q < CNT_W'(2)) ? '0 : rd1;
endmodule

// File: tb/tb_data_stack.sv
// tb_data_stack: directed and randomized checks of data_stack against a queue-based LIFO model.
module tb_data_stack;
   localparam int DEPTH = 32;
   logic        clk = 1'b0, rst = 1'b1;
   logic        clear = 1'b0, push = 1'b0, pop = 1'b0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out, tos, nos;
   logic [5:0]  count;
   logic        empty, full, overflow, underflow;
   int checks = 0, errors = 0;
   logic [15:0] mq [$];
   logic [15:0] m_out;
   logic        m_ovf, m_unf;

   data_stack dut (
      .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop), .data_in(data_in),
      .data_out(data_out), .tos(tos), .nos(nos), .count(count), .empty(empty),
      .full(full), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      mq.delete();
      m_out = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_apply(input logic c, input logic pu, input logic po, input logic [15:0] d);
      if (c) begin
         model_reset();
         return;
      end
      if (po) begin
         if (mq.size() > 0) m_out = mq.pop_back();
         else m_unf = 1'b1;
      end
      if (pu) begin
         if (mq.size() < DEPTH) mq.push_back(d);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic cycle(input logic c, input logic pu, input logic po, input logic [15:0] d);
      clear = c; push = pu; pop = po; data_in = d;
      @(posedge clk);
      #1;
      model_apply(c, pu, po, d);
      clear = 1'b0; push = 1'b0; pop = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      checks++;
      if ({count, empty, full, overflow, underflow} !== {6'd0, 4'b1000}) begin
         errors++;
         $display("FAIL reset_state got cnt=%0d e=%b f=%b o=%b u=%b exp cnt=0 e=1 f=0 o=0 u=0",
                  count, empty, full, overflow, underflow);
      end
      checks++;
      if ({data_out, tos, nos} !== 48'd0) begin
         errors++;
         $display("FAIL reset_data got out=%h tos=%h nos=%h exp all 0", data_out, tos, nos);
      end
   endtask

   task automatic test_push_pop();
      for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, 1'b0, 16'(i));
      checks++;
      if ({count, tos, nos, empty, full} !== {6'd3, 16'h0003, 16'h0002, 2'b00}) begin
         errors++;
         $display("FAIL push3 got cnt=%0d tos=%h nos=%h e=%b f=%b exp cnt=3 tos=0003 nos=0002 e=0 f=0",
                  count, tos, nos, empty, full);
      end
      cycle(1'b0, 1'b0, 1'b1, '0);
      checks++;
      if (data_out !== 16'h0003) begin
         errors++;
         $display("FAIL pop1_out got %h exp 0003", data_out);
      end
      cycle(1'b0, 1'b0, 1'b1, '0);
      checks++;
      if ({data_out, count, tos, nos} !== {16'h0002, 6'd1, 16'h0001, 16'h0000}) begin
         errors++;
         $display("FAIL pop2 got out=%h cnt=%0d tos=%h nos=%h exp out=0002 cnt=1 tos=0001 nos=0000",
                  data_out, count, tos, nos);
      end
   endtask

   task automatic test_overflow();
      cycle(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i));
      checks++;
      if ({full, overflow, count} !== {2'b10, 6'd32}) begin
         errors++;
         $display("FAIL fill32 got f=%b o=%b cnt=%0d exp f=1 o=0 cnt=32", full, overflow, count);
      end
      cycle(1'b0, 1'b1, 1'b0, 16'hBEEF);
      checks++;
      if ({full, count, overflow, tos} !== {1'b1, 6'd32, 1'b1, 16'h011F}) begin
         errors++;
         $display("FAIL overflow got f=%b cnt=%0d o=%b tos=%h exp f=1 cnt=32 o=1 tos=011f",
                  full, count, overflow, tos);
      end
      cycle(1'b0, 1'b1, 1'b1, 16'h1234);
      checks++;
      if ({data_out, tos, nos, count} !== {16'h011F, 16'h1234, 16'h011E, 6'd32}) begin
         errors++;
         $display("FAIL full_pushpop got out=%h tos=%h nos=%h cnt=%0d exp out=011f tos=1234 nos=011e cnt=32",
                  data_out, tos, nos, count);
      end
   endtask

   task automatic test_underflow();
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, 1'b1, '0);
      checks++;
      if ({underflow, data_out, count, empty} !== {1'b1, 16'h0000, 6'd0, 1'b1}) begin
         errors++;
         $display("FAIL underflow got u=%b out=%h cnt=%0d e=%b exp u=1 out=0000 cnt=0 e=1",
                  underflow, data_out, count, empty);
      end
      cycle(1'b0, 1'b1, 1'b1, 16'h00AA);
      checks++;
      if ({count, tos, underflow, data_out} !== {6'd1, 16'h00AA, 1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL empty_pushpop got cnt=%0d tos=%h u=%b out=%h exp cnt=1 tos=00aa u=1 out=0000",
                  count, tos, underflow, data_out);
      end
   endtask

   task automatic test_clear();
      cycle(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 33; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0200 + 16'(i));
      for (int i = 0; i < 27; i++) cycle(1'b0, 1'b0, 1'b1, '0);
      checks++;
      if ({count, overflow, data_out} !== {6'd5, 1'b1, 16'h0205}) begin
         errors++;
         $display("FAIL preclear got cnt=%0d o=%b out=%h exp cnt=5 o=1 out=0205", count, overflow, data_out);
      end
      cycle(1'b1, 1'b1, 1'b0, 16'h7777);
      checks++;
      if ({count, empty, overflow, underflow, data_out, tos} !== {6'd0, 3'b100, 32'd0}) begin
         errors++;
         $display("FAIL clear got cnt=%0d e=%b o=%b u=%b out=%h tos=%h exp cnt=0 e=1 o=0 u=0 out=0 tos=0",
                  count, empty, overflow, underflow, data_out, tos);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0300 + 16'(i));
      cycle(1'b0, 1'b0, 1'b1, '0);
      cycle(1'b0, 1'b1, 1'b0, 16'h0AAA);
      push = 1'b1;
      data_in = 16'h0BBB;
      #2 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if ({count, data_out, overflow, underflow, empty, tos} !== {6'd0, 16'd0, 3'b001, 16'd0}) begin
         errors++;
         $display("FAIL async_reset got cnt=%0d out=%h o=%b u=%b e=%b tos=%h exp cnt=0 out=0 o=0 u=0 e=1 tos=0",
                  count, data_out, overflow, underflow, empty, tos);
      end
      push = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_random();
      logic c, pu, po;
      logic [15:0] d, e_tos, e_nos;
      logic [5:0] e_cnt;
      for (int i = 0; i < 600; i++) begin
         c  = ($urandom_range(0, 39) == 0);
         pu = (i % 200 < 100) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
         po = (i % 200 < 100) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
         d  = 16'($urandom);
         cycle(c, pu, po, d);
         e_cnt = 6'(mq.size());
         e_tos = (mq.size() > 0) ? mq[mq.size()-1] : 16'd0;
         e_nos = (mq.size() > 1) ? mq[mq.size()-2] : 16'd0;
         checks++;
         if ({count, empty, full, overflow, underflow, tos, nos, data_out} !==
             {e_cnt, e_cnt == 6'd0, e_cnt == 6'd32, m_ovf, m_unf, e_tos, e_nos, m_out}) begin
            errors++;
            $display("FAIL random[%0d] got cnt=%0d e=%b f=%b o=%b u=%b tos=%h nos=%h out=%h exp cnt=%0d o=%b u=%b tos=%h nos=%h out=%h",
                     i, count, empty, full, overflow, underflow, tos, nos, data_out,
                     e_cnt, m_ovf, m_unf, e_tos, e_nos, m_out);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_push_pop();
      test_overflow();
      test_underflow();
      test_clear();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
